// File: rtl/ps2_scancode_decoder_if.sv
// Byte-in / key-event-out bundle for the PS2 scancode decoder; slave = decoder side.
// event_count is FIFO_AW+1 bits wide so a full FIFO of 2**FIFO_AW events is representable.
interface ps2_scancode_decoder_if #(
  parameter int FIFO_AW = 3
);
  logic [7:0]       received_data;
  logic             received_data_en;
  logic             event_read;
  logic             clear_overflow;
  logic             event_valid;
  logic [7:0]       event_code;
  logic             event_extended;
  logic             event_break;
  logic [FIFO_AW:0] event_count;
  logic             overflow;
  logic [7:0]       status_code;
  logic             status_en;

  modport slave (
    input  received_data, received_data_en, event_read, clear_overflow,
    output event_valid, event_code, event_extended, event_break,
           event_count, overflow, status_code, status_en
  );

  modport master (
    output received_data, received_data_en, event_read, clear_overflow,
    input  event_valid, event_code, event_extended, event_break,
           event_count, overflow, status_code, status_en
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scancode decoder into a show-ahead key-event FIFO; event visible the cycle after its last byte.
// No input backpressure: a full FIFO drops events (sticky overflow); PS2_DECODER_TYPEMATIC_FILTER_EN drops auto-repeat makes.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  ps2_scancode_decoder_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0,
    ST_PAUSE
  } state_t;

  localparam logic [FIFO_AW:0] LP_FULL = (FIFO_AW+1)'(FIFO_DEPTH);

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_pause_cnt, w_pause_nxt;
  logic               w_evt, w_evt_ext, w_evt_brk, w_push;
  logic [7:0]         w_evt_code;
  logic               w_status, w_is_status;

  logic [9:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [FIFO_AW:0]   r_count, w_count_nxt;
  logic [9:0]         r_head, w_push_dat;
  logic               w_full, w_pop, w_wr;
  logic               r_overflow;
  logic [7:0]         r_status_code;
  logic               r_status_en;

  always_comb begin
    w_is_status = bus.received_data inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_pause_cnt <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_pause_cnt <= w_pause_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pause_nxt = r_pause_cnt;
    w_evt       = 1'b0;
    w_evt_ext   = 1'b0;
    w_evt_brk   = 1'b0;
    w_evt_code  = bus.received_data;
    w_status    = 1'b0;
    if (bus.received_data_en) begin
      if (r_state == ST_PAUSE) begin
        // Pause swallows everything, status bytes included, until its fixed length is consumed.
        w_pause_nxt = r_pause_cnt - 3'd1;
        if (r_pause_cnt <= 3'd1) begin
          w_evt       = 1'b1;
          w_evt_code  = 8'hE1;
          w_state_nxt = ST_IDLE;
        end
      end else if (w_is_status) begin
        w_status    = 1'b1;
        w_state_nxt = ST_IDLE;
      end else if (bus.received_data == 8'hE1) begin
        w_state_nxt = ST_PAUSE;
        w_pause_nxt = 3'd7;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (bus.received_data == 8'hE0)      w_state_nxt = ST_GOT_E0;
            else if (bus.received_data == 8'hF0) w_state_nxt = ST_GOT_F0;
            else                                 w_evt = 1'b1;
          end
          ST_GOT_E0: begin
            if (bus.received_data == 8'hF0)      w_state_nxt = ST_GOT_E0F0;
            else if (bus.received_data != 8'hE0) begin
              w_evt       = 1'b1;
              w_evt_ext   = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end
          ST_GOT_F0: begin
            if (bus.received_data == 8'hE0)      w_state_nxt = ST_GOT_E0;
            else if (bus.received_data != 8'hF0) begin
              w_evt       = 1'b1;
              w_evt_brk   = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end
          ST_GOT_E0F0: begin
            if (bus.received_data != 8'hE0 && bus.received_data != 8'hF0) begin
              w_evt       = 1'b1;
              w_evt_ext   = 1'b1;
              w_evt_brk   = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end
    end
  end

`ifdef PS2_DECODER_TYPEMATIC_FILTER_EN
  logic [8:0] r_last_make;
  logic       r_last_vld;
  logic       w_match, w_is_make;

  always_comb begin
    w_match   = r_last_vld && (r_last_make == {w_evt_ext, w_evt_code});
    w_is_make = w_evt && !w_evt_brk && (r_state != ST_PAUSE);
    w_push    = w_evt && !(w_is_make && w_match);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_make <= 9'd0;
      r_last_vld  <= 1'b0;
    end else if (w_is_make && !w_match) begin
      r_last_make <= {w_evt_ext, w_evt_code};
      r_last_vld  <= 1'b1;
    end else if (w_evt && w_evt_brk && w_match) begin
      r_last_vld  <= 1'b0;
    end
  end
`else
  assign w_push = w_evt;
`endif

  assign w_push_dat  = {w_evt_ext, w_evt_brk, w_evt_code};
  assign w_full      = (r_count == LP_FULL);
  assign w_pop       = bus.event_read && (r_count != '0);
  assign w_wr        = w_push && (!w_full || w_pop);
  assign w_rd_nxt    = r_rd_ptr + FIFO_AW'(w_pop);
  assign w_count_nxt = r_count + (FIFO_AW+1)'(w_wr) - (FIFO_AW+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_push_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_head        <= 10'd0;
      r_overflow    <= 1'b0;
      r_status_code <= 8'd0;
      r_status_en   <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      // Head is registered so it can hold its last value once the FIFO drains.
      if (w_count_nxt != '0) begin
        if (w_wr && (r_wr_ptr == w_rd_nxt)) r_head <= w_push_dat;
        else                                r_head <= r_mem[w_rd_nxt];
      end
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      else if (bus.clear_overflow)    r_overflow <= 1'b0;
      r_status_en <= w_status;
      if (w_status) r_status_code <= bus.received_data;
    end
  end

  assign bus.event_valid    = (r_count != '0);
  assign bus.event_extended = r_head[9];
  assign bus.event_break    = r_head[8];
  assign bus.event_code     = r_head[7:0];
  assign bus.event_count    = r_count;
  assign bus.overflow       = r_overflow;
  assign bus.status_code    = r_status_code;
  assign bus.status_en      = r_status_en;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder; inputs change and outputs are sampled on the falling edge.
// Build with +define+PS2_DECODER_TYPEMATIC_FILTER_EN to exercise the auto-repeat filter.
module tb_ps2_scancode_decoder;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  ps2_scancode_decoder_if #(.FIFO_AW(3)) bus_if ();

  ps2_scancode_decoder #(.FIFO_DEPTH(8), .FIFO_AW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_evt(input string tag, input logic vld, input logic [7:0] code,
                           input logic ext, input logic brk, input logic [3:0] cnt);
    check({tag, ".valid"}, 32'(bus_if.event_valid), 32'(vld));
    check({tag, ".code"},  32'(bus_if.event_code), 32'(code));
    check({tag, ".ext"},   32'(bus_if.event_extended), 32'(ext));
    check({tag, ".brk"},   32'(bus_if.event_break), 32'(brk));
    check({tag, ".count"}, 32'(bus_if.event_count), 32'(cnt));
  endtask

  // One cycle of drive, starting and ending on a falling edge.
  task automatic step(input logic [7:0] b, input logic en, input logic rd, input logic clr);
    @(negedge clk);
    bus_if.received_data    = b;
    bus_if.received_data_en = en;
    bus_if.event_read       = rd;
    bus_if.clear_overflow   = clr;
    @(negedge clk);
    bus_if.received_data_en = 1'b0;
    bus_if.event_read       = 1'b0;
    bus_if.clear_overflow   = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    step(b, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] drain_exp [8];
    checks   = 0;
    failures = 0;
    drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
    reset = 1'b0;
    bus_if.received_data    = 8'h00;
    bus_if.received_data_en = 1'b0;
    bus_if.event_read       = 1'b0;
    bus_if.clear_overflow   = 1'b0;
    repeat (3) @(negedge clk);
    check_evt("reset", 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    check("reset.overflow", 32'(bus_if.overflow), 32'd0);
    check("reset.status_code", 32'(bus_if.status_code), 32'd0);
    check("reset.status_en", 32'(bus_if.status_en), 32'd0);
    reset = 1'b1;

    // Single make, then read it out; code holds after the FIFO drains.
    send(8'h1C);
    check_evt("make1c", 1'b1, 8'h1C, 1'b0, 1'b0, 4'd1);
    pop();
    check_evt("make1c_read", 1'b0, 8'h1C, 1'b0, 1'b0, 4'd0);

    // Plain break and extended break.
    send(8'hF0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h75);
    check_evt("brk1c", 1'b1, 8'h1C, 1'b0, 1'b1, 4'd2);
    pop();
    check_evt("ebrk75", 1'b1, 8'h75, 1'b1, 1'b1, 4'd1);
    pop();
    check_evt("brk_drain", 1'b0, 8'h75, 1'b1, 1'b1, 4'd0);

    // Pause sequence yields one E1 event on its final byte.
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1); send(8'hF0); send(8'h14); send(8'hF0);
    check("pause_mid.count", 32'(bus_if.event_count), 32'd0);
    send(8'h77);
    check_evt("pause", 1'b1, 8'hE1, 1'b0, 1'b0, 4'd1);
    send(8'h1C);
    check("pause_next.count", 32'(bus_if.event_count), 32'd2);
    pop();
    check_evt("pause_next", 1'b1, 8'h1C, 1'b0, 1'b0, 4'd1);
    pop();

    // Status bytes, including one that aborts an E0 prefix.
    send(8'hAA);
    check("stat_aa.en", 32'(bus_if.status_en), 32'd1);
    check("stat_aa.code", 32'(bus_if.status_code), 32'hAA);
    @(negedge clk);
    check("stat_aa.pulse_end", 32'(bus_if.status_en), 32'd0);
    send(8'hE0); send(8'hFA);
    check("stat_fa.en", 32'(bus_if.status_en), 32'd1);
    check("stat_fa.code", 32'(bus_if.status_code), 32'hFA);
    check("stat_fa.count", 32'(bus_if.event_count), 32'd0);
    send(8'h2A);
    check_evt("after_stat", 1'b1, 8'h2A, 1'b0, 1'b0, 4'd1);
    pop();

    // Fill past full: 01..08 kept, 09 dropped.
    for (int i = 1; i <= 9; i++) send(8'(i));
    check_evt("full", 1'b1, 8'h01, 1'b0, 1'b0, 4'd8);
    check("full.overflow", 32'(bus_if.overflow), 32'd1);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    check("clr.overflow", 32'(bus_if.overflow), 32'd0);
    step(8'h0A, 1'b1, 1'b1, 1'b0);
    check_evt("full_pushpop", 1'b1, 8'h02, 1'b0, 1'b0, 4'd8);
    check("full_pushpop.overflow", 32'(bus_if.overflow), 32'd0);
    send(8'h0B);
    check("drop.overflow", 32'(bus_if.overflow), 32'd1);
    check("drop.count", 32'(bus_if.event_count), 32'd8);
    step(8'h0C, 1'b1, 1'b0, 1'b1);
    check("drop_vs_clr.overflow", 32'(bus_if.overflow), 32'd1);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    check("clr2.overflow", 32'(bus_if.overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("drain.code", 32'(bus_if.event_code), 32'(drain_exp[i]));
      pop();
    end
    check("drain.count", 32'(bus_if.event_count), 32'd0);

    // Push and pop together on an empty FIFO: pop ignored.
    step(8'h1C, 1'b1, 1'b1, 1'b0);
    check_evt("empty_pushpop", 1'b1, 8'h1C, 1'b0, 1'b0, 4'd1);
    pop();

    // Reset between E0 and F0 discards the prefix.
    send(8'hE0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_evt("midreset", 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    reset = 1'b1;
    send(8'h75);
    check_evt("after_reset", 1'b1, 8'h75, 1'b0, 1'b0, 4'd1);
    pop();

    // Auto-repeat sequence.
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
`ifdef PS2_DECODER_TYPEMATIC_FILTER_EN
    check_evt("typ0", 1'b1, 8'h1C, 1'b0, 1'b0, 4'd3);
    pop();
    check_evt("typ1", 1'b1, 8'h1C, 1'b0, 1'b1, 4'd2);
    pop();
    check_evt("typ2", 1'b1, 8'h1C, 1'b0, 1'b0, 4'd1);
    pop();
`else
    check_evt("rep0", 1'b1, 8'h1C, 1'b0, 1'b0, 4'd5);
    pop(); pop(); pop();
    check_evt("rep3", 1'b1, 8'h1C, 1'b0, 1'b1, 4'd2);
    pop();
    check_evt("rep4", 1'b1, 8'h1C, 1'b0, 1'b0, 4'd1);
    pop();
`endif
    check("final.count", 32'(bus_if.event_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
